// File: rtl/seg_pkg.sv
// Shared 7-segment constants, tracker state type and the digit encode helper
// for the segment decoder and the display driver.
package seg_pkg;

    localparam int SEG_W = 7;
    localparam int CNT_W = 3;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    typedef enum logic [1:0] {
        TRK_TRACK = 2'd0,
        TRK_COUNT = 2'd1,
        TRK_EVENT = 2'd2,
        TRK_HOLD  = 2'd3
    } trk_state_e;

    function automatic logic [SEG_W-1:0] seg_encode(input logic [CNT_W-1:0] c);
        logic [SEG_W-1:0] p;
        case (c)
            3'd0:    p = SEG_0;
            3'd1:    p = SEG_1;
            3'd2:    p = SEG_2;
            3'd3:    p = SEG_3;
            3'd4:    p = SEG_4;
            3'd5:    p = SEG_5;
            3'd6:    p = SEG_6;
            3'd7:    p = SEG_7;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_decoder_lookup.sv
// Combinational segment pattern classifier: pattern -> {legal, is_blank, count}.
module seg_lookup
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             legal,
    output logic             is_blank,
    output logic [CNT_W-1:0] count
);

    assign is_blank = (pattern == SEG_BLANK);

    // decode a legal digit pattern back to its count
    always_comb begin
        legal = 1'b1;
        count = 3'd0;
        case (pattern)
            SEG_0:   count = 3'd0;
            SEG_1:   count = 3'd1;
            SEG_2:   count = 3'd2;
            SEG_3:   count = 3'd3;
            SEG_4:   count = 3'd4;
            SEG_5:   count = 3'd5;
            SEG_6:   count = 3'd6;
            SEG_7:   count = 3'd7;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_decoder.sv
// Recovers a 3-bit count from a 7-segment bus: synchronise, debounce, decode, buffer.
// Build option SEG_DEC_ACTIVE_LOW_EN inverts the synchronised sample for common-anode displays.
module seg_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEG_W-1:0] lights,
    output logic [CNT_W-1:0] count_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pattern_err,
    output logic             overrun
);

    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] sync_r [SYNC_STAGES];
    logic [SEG_W-1:0] sample_s;
    logic [SEG_W-1:0] prev_r;
    logic [SEG_W-1:0] prev_nxt_s;
    logic [3:0]       stab_cnt_r;
    logic [3:0]       stab_cnt_nxt_s;
    logic             armed_r;
    logic             armed_nxt_s;
    trk_state_e       trk_state_s;
    logic             event_s;
    logic             lk_legal_s;
    logic             lk_blank_s;
    logic [CNT_W-1:0] lk_count_s;

    // segment bus synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {SEG_W{1'b0}};
        end else begin
            sync_r[0] <= lights;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

`ifdef SEG_DEC_ACTIVE_LOW_EN
    assign sample_s = ~sync_r[SYNC_STAGES-1];
`else
    assign sample_s = sync_r[SYNC_STAGES-1];
`endif

    // classify this cycle's tracker action and compute its next state
    always_comb begin
        prev_nxt_s     = prev_r;
        stab_cnt_nxt_s = stab_cnt_r;
        armed_nxt_s    = armed_r;
        if (sample_s != prev_r) begin
            trk_state_s = TRK_TRACK;
        end else if (stab_cnt_r < STAB_LAST) begin
            trk_state_s = TRK_COUNT;
        end else if (armed_r) begin
            trk_state_s = TRK_EVENT;
        end else begin
            trk_state_s = TRK_HOLD;
        end
        case (trk_state_s)
            TRK_TRACK: begin
                prev_nxt_s     = sample_s;
                stab_cnt_nxt_s = 4'd0;
                armed_nxt_s    = 1'b1;
            end
            TRK_COUNT: stab_cnt_nxt_s = stab_cnt_r + 4'd1;
            TRK_EVENT: armed_nxt_s = 1'b0;
            TRK_HOLD:  armed_nxt_s = armed_r;
            default:   armed_nxt_s = armed_r;
        endcase
    end

    // stability tracker registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r     <= SEG_BLANK;
            stab_cnt_r <= 4'd0;
            armed_r    <= 1'b0;
        end else begin
            prev_r     <= prev_nxt_s;
            stab_cnt_r <= stab_cnt_nxt_s;
            armed_r    <= armed_nxt_s;
        end
    end

    assign event_s = (trk_state_s == TRK_EVENT);

    seg_lookup u_lookup (
        .pattern  (prev_r),
        .legal    (lk_legal_s),
        .is_blank (lk_blank_s),
        .count    (lk_count_s)
    );

    // one-deep output buffer, error pulse and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_out   <= 3'd0;
            out_valid   <= 1'b0;
            pattern_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pattern_err <= event_s & ~lk_legal_s & ~lk_blank_s;
            if (event_s && lk_legal_s) begin
                // a handshake this cycle frees the slot for the new count
                if (!out_valid || out_ready) begin
                    count_out <= lk_count_s;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_decoder.sv
// Scoreboard bench for seg_decoder: a run-length reference model predicts
// deliveries and error pulses; a negedge monitor checks what the DUT presents.
module tb_seg_decoder;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;
`ifdef SEG_DEC_ACTIVE_LOW_EN
    localparam logic [6:0] MASK = 7'h7F;
`else
    localparam logic [6:0] MASK = 7'h00;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] lights = 7'h00;
    logic [2:0] count_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       pattern_err;
    logic       overrun;

    seg_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .lights      (lights),
        .count_out   (count_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pattern_err (pattern_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] codes [8] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

    int checks = 0;
    int errors = 0;
    int q[$];
    int exp_err = 0;
    int err_seen = 0;
    int deliveries = 0;
    bit err_prev = 1'b0;
    bit push_en = 1'b1;
    logic [6:0] run_val;
    int run_len;
    bit fired;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every maximal run of one logical pattern lasting STABLE+1
    // samples produces exactly one event; legal codes deliver, blank is ignored.
    task automatic model_sample(input logic [6:0] v);
        int idx;
        if (v != run_val) begin
            run_val = v;
            run_len = 1;
            fired   = 1'b0;
        end else begin
            run_len++;
        end
        if (!fired && run_len >= STABLE + 1) begin
            fired = 1'b1;
            idx = -1;
            for (int k = 0; k < 8; k++) if (codes[k] == v) idx = k;
            if (idx >= 0) begin
                if (push_en) q.push_back(idx);
            end else if (v != 7'h00) begin
                exp_err++;
            end
        end
    endtask

    // the synchroniser's reset contents reach the tracker before real input
    task automatic model_reset();
        run_val = 7'h00;
        run_len = 1000;
        fired   = 1'b1;
        for (int i = 0; i < SYNC; i++) model_sample(MASK);
    endtask

    task automatic drive(input logic [6:0] v);
        lights = v ^ MASK;
        model_sample(v);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        lights = MASK;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        model_reset();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                deliveries++;
                if (q.size() == 0) begin
                    check("unexpected_delivery", int'(count_out), -1);
                end else begin
                    check("count_out", int'(count_out), q.pop_front());
                end
            end
            if (pattern_err) begin
                err_seen++;
                check("pattern_err_width", int'(err_prev), 0);
            end
            err_prev = pattern_err;
        end else begin
            err_prev = 1'b0;
        end
    end

    initial begin
        int d0;
        int e0;
        logic [6:0] v;
        int r;

        do_reset();
        check("reset_valid", int'(out_valid), 0);
        check("reset_count", int'(count_out), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_err", int'(pattern_err), 0);

        // latency: pattern settled before edge 1 is presented after edge 7
        for (int e = 1; e <= 10; e++) begin
            drive(7'h5F);
            check("lat_valid", int'(out_valid), (e == 7) ? 1 : 0);
            if (e == 7) check("lat_count", int'(count_out), 6);
        end

        // sweep of all legal codes
        d0 = deliveries;
        for (int k = 0; k < 8; k++) hold(codes[k], 8);
        hold(codes[7], 4);
        check("sweep_deliveries", deliveries - d0, 8);
        check("sweep_err", err_seen, 0);
        check("sweep_overrun", int'(overrun), 0);

        // a three-sample glitch is filtered out
        d0 = deliveries;
        hold(7'h30, 3);
        hold(7'h79, 10);
        check("glitch_deliveries", deliveries - d0, 1);

        // illegal pattern pulses once; blank is silent
        d0 = deliveries;
        e0 = err_seen;
        hold(7'h7F, 10);
        check("illegal_err", err_seen - e0, 1);
        hold(7'h00, 10);
        check("blank_err", err_seen - e0, 1);
        check("illegal_blank_deliveries", deliveries - d0, 0);

        // randomized pattern runs
        for (int s = 0; s < 80; s++) begin
            r = $urandom_range(0, 9);
            if (r < 8) v = codes[r];
            else if (r == 8) v = 7'h00;
            else v = 7'($urandom_range(0, 127));
            hold(v, $urandom_range(1, 9));
        end
        hold(run_val, 8);
        check("random_err_total", err_seen, exp_err);
        check("random_drained", q.size(), 0);

        // overrun: second count dropped while the buffer is held full
        out_ready = 1'b0;
        hold(7'h6D, 8);
        push_en = 1'b0;
        hold(7'h5B, 8);
        push_en = 1'b1;
        check("ovr_valid", int'(out_valid), 1);
        check("ovr_count", int'(count_out), 2);
        check("ovr_flag", int'(overrun), 1);
        out_ready = 1'b1;
        drive(7'h5B);
        check("ovr_consumed", int'(out_valid), 0);
        hold(7'h5B, 3);
        check("ovr_sticky", int'(overrun), 1);

        // asynchronous reset while a count is buffered
        out_ready = 1'b0;
        hold(7'h33, 8);
        check("pre_reset_valid", int'(out_valid), 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_count", int'(count_out), 0);
        check("async_overrun", int'(overrun), 0);
        check("async_err", int'(pattern_err), 0);
        out_ready = 1'b1;
        do_reset();
        hold(7'h70, 10);
        check("post_reset_overrun", int'(overrun), 0);

        hold(run_val, 4);
        check("queue_empty", q.size(), 0);
        check("err_total", err_seen, exp_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
